// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: control-signal pipeline for a 5-stage in-order core.
// Carries the EX/M/WB decode bundles through ID/EX, EX/MEM and MEM/WB,
// resolves the destination register in EX, and raises the load-use stall
// and the taken-branch flush.
// Optional build macro: CTRL_PIPELINE_STATS_EN adds bubble_cnt, a saturating
// count of edges at which a stall or flush inserted a bubble.
module ctrl_pipeline (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_ex,      // {RegDst, ALUOp[1:0], ALUSrc}
    input  logic [2:0]  id_m,       // {Branch, MemRead, MemWrite}
    input  logic [1:0]  id_wb,      // {RegWrite, MemtoReg}
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        mem_zero,
    output logic        stall,
    output logic        flush,
    output logic [3:0]  ex_ctrl,
    output logic [2:0]  mem_ctrl,
    output logic [1:0]  wb_ctrl,
    output logic [4:0]  mem_dest,
    output logic [4:0]  wb_dest
`ifdef CTRL_PIPELINE_STATS_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    // Only a definite 1 enables a control bit; X/Z from don't-care
    // encodings must never leak into the pipeline as a live control.
    function automatic logic [8:0] only_ones(input logic [8:0] v);
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    logic [8:0] ctl_c;
    assign ctl_c = only_ones({id_ex, id_m, id_wb});

    // ID/EX
    logic [3:0] idex_ex_q,  idex_ex_d;
    logic [2:0] idex_m_q,   idex_m_d;
    logic [1:0] idex_wb_q,  idex_wb_d;
    logic [4:0] idex_rt_q,  idex_rt_d;
    logic [4:0] idex_rd_q,  idex_rd_d;
    // EX/MEM
    logic [2:0] exm_m_q,    exm_m_d;
    logic [1:0] exm_wb_q,   exm_wb_d;
    logic [4:0] exm_dest_q, exm_dest_d;
    // MEM/WB
    logic [1:0] mwb_wb_q,   mwb_wb_d;
    logic [4:0] mwb_dest_q, mwb_dest_d;

    // Hazard detection: branch resolves in MEM; load-use checks the load in EX
    // against the source fields in decode. A flush squashes the load anyway,
    // so it masks the stall.
    always_comb begin
        flush = exm_m_q[2] & mem_zero;
        stall = idex_m_q[1] & (idex_rt_q != 5'd0)
              & ((idex_rt_q == id_rs) | (idex_rt_q == id_rt))
              & ~flush;
    end

    // Next-state for all three pipeline registers; a flush or stall turns the
    // ID/EX slot into a bubble, a flush also kills the EX/MEM slot.
    always_comb begin
        idex_ex_d  = ctl_c[8:5];
        idex_m_d   = ctl_c[4:2];
        idex_wb_d  = ctl_c[1:0];
        idex_rt_d  = id_rt;
        idex_rd_d  = id_rd;
        exm_m_d    = idex_m_q;
        exm_wb_d   = idex_wb_q;
        exm_dest_d = idex_ex_q[3] ? idex_rd_q : idex_rt_q;
        mwb_wb_d   = exm_wb_q;
        mwb_dest_d = exm_dest_q;
        if (flush || stall) begin
            idex_ex_d = '0;
            idex_m_d  = '0;
            idex_wb_d = '0;
            idex_rt_d = '0;
            idex_rd_d = '0;
        end
        if (flush) begin
            exm_m_d    = '0;
            exm_wb_d   = '0;
            exm_dest_d = '0;
        end
    end

    // Pipeline registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ex_q  <= '0;
            idex_m_q   <= '0;
            idex_wb_q  <= '0;
            idex_rt_q  <= '0;
            idex_rd_q  <= '0;
            exm_m_q    <= '0;
            exm_wb_q   <= '0;
            exm_dest_q <= '0;
            mwb_wb_q   <= '0;
            mwb_dest_q <= '0;
        end else begin
            idex_ex_q  <= idex_ex_d;
            idex_m_q   <= idex_m_d;
            idex_wb_q  <= idex_wb_d;
            idex_rt_q  <= idex_rt_d;
            idex_rd_q  <= idex_rd_d;
            exm_m_q    <= exm_m_d;
            exm_wb_q   <= exm_wb_d;
            exm_dest_q <= exm_dest_d;
            mwb_wb_q   <= mwb_wb_d;
            mwb_dest_q <= mwb_dest_d;
        end
    end

    assign ex_ctrl  = idex_ex_q;
    assign mem_ctrl = exm_m_q;
    assign wb_ctrl  = mwb_wb_q;
    assign mem_dest = exm_dest_q;
    assign wb_dest  = mwb_dest_q;

`ifdef CTRL_PIPELINE_STATS_EN
    logic [15:0] bubble_q, bubble_d;

    // Saturating bubble counter; stall and flush are exclusive so one step max.
    always_comb begin
        bubble_d = bubble_q;
        if ((stall || flush) && (bubble_q != 16'hFFFF))
            bubble_d = bubble_q + 16'd1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_q <= '0;
        else        bubble_q <= bubble_d;
    end

    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: scoreboard bench for ctrl_pipeline. Each stimulus step
// pushes the outputs it should produce, tagged with the cycle they must
// appear in; a negedge checker pops and compares them.
module tb_ctrl_pipeline;

    localparam int S_EX = 0, S_MEM = 1, S_WB = 2, S_MD = 3, S_WD = 4,
                   S_STALL = 5, S_FLUSH = 6, S_BC = 7;

    logic        clk, rst_n;
    logic [3:0]  id_ex;
    logic [2:0]  id_m;
    logic [1:0]  id_wb;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        mem_zero;
    logic        stall, flush;
    logic [3:0]  ex_ctrl;
    logic [2:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [4:0]  mem_dest, wb_dest;
`ifdef CTRL_PIPELINE_STATS_EN
    logic [15:0] bubble_cnt;
`endif

    ctrl_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .mem_zero(mem_zero),
        .stall(stall), .flush(flush),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .mem_dest(mem_dest), .wb_dest(wb_dest)
`ifdef CTRL_PIPELINE_STATS_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          sig;
        logic [15:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] obs_sig(input int sig);
        case (sig)
            S_EX:    return 16'(ex_ctrl);
            S_MEM:   return 16'(mem_ctrl);
            S_WB:    return 16'(wb_ctrl);
            S_MD:    return 16'(mem_dest);
            S_WD:    return 16'(wb_dest);
            S_STALL: return 16'(stall);
            S_FLUSH: return 16'(flush);
`ifdef CTRL_PIPELINE_STATS_EN
            S_BC:    return bubble_cnt;
`endif
            default: return 16'hDEAD;
        endcase
    endfunction

    // Bit-level rule for decode bundles: anything but a definite 1 latches 0.
    function automatic logic [3:0] cl4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    task automatic exp_at(input int off, input int sig, input logic [15:0] v, input string tag);
        exp_t e;
        e.cyc = cyc + off; e.sig = sig; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_bc(input int off, input logic [15:0] v, input string tag);
`ifdef CTRL_PIPELINE_STATS_EN
        exp_at(off, S_BC, v, tag);
`else
        if (v == 16'hFFFF) $display("note: %s unused without stats (%0d)", tag, off);
`endif
    endtask

    // Scoreboard checker: pop every expectation due this cycle.
    int k;
    always @(negedge clk) begin
        if (rst_n) begin
            k = 0;
            while (k < sb.size()) begin
                if (sb[k].cyc <= cyc) begin
                    chk(sb[k].tag, (sb[k].cyc == cyc) ? obs_sig(sb[k].sig) : 16'hDEAD, sb[k].val);
                    sb.delete(k);
                end else k++;
            end
        end
    end

    task automatic drv(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic mz);
        id_ex = ex; id_m = m; id_wb = wb;
        id_rs = rs; id_rt = rt; id_rd = rd;
        mem_zero = mz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        repeat (n) begin
            drv(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            tick();
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_ex"},    16'(ex_ctrl),  16'h0);
        chk({pfx, "_mem"},   16'(mem_ctrl), 16'h0);
        chk({pfx, "_wb"},    16'(wb_ctrl),  16'h0);
        chk({pfx, "_md"},    16'(mem_dest), 16'h0);
        chk({pfx, "_wd"},    16'(wb_dest),  16'h0);
        chk({pfx, "_stall"}, 16'(stall),    16'h0);
        chk({pfx, "_flush"}, 16'(flush),    16'h0);
`ifdef CTRL_PIPELINE_STATS_EN
        chk({pfx, "_bc"},    bubble_cnt,    16'h0);
`endif
    endtask

    logic [3:0] bex, bsw;
    logic [1:0] bwb;
    logic [3:0] cwb;

    initial begin
        rst_n = 1'b0;
        drv(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #12;
        chk_all_zero("rst");
        @(negedge clk); #2 rst_n = 1'b1;
        tick();

        // R-type: 1/2/3-cycle latency, dest = rd
        drv(4'b1100, 3'b000, 2'b10, 5'd0, 5'd2, 5'd3, 1'b0);
        exp_at(0, S_STALL, 16'h0, "rt_nostall");
        exp_at(1, S_EX,  16'hC, "rt_ex");
        exp_at(2, S_MEM, 16'h0, "rt_mem");
        exp_at(2, S_MD,  16'd3, "rt_md");
        exp_at(3, S_WB,  16'h2, "rt_wb");
        exp_at(3, S_WD,  16'd3, "rt_wd");
        tick();
        // NOP with zero flag high never flushes or stalls
        drv(4'b0, 3'b0, 2'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        exp_at(0, S_FLUSH, 16'h0, "nop_flush");
        exp_at(0, S_STALL, 16'h0, "nop_stall");
        tick();
        nop(4);

        // LW then dependent: one stall, bubble in EX
        drv(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0);
        exp_at(0, S_STALL, 16'h0, "lw_nostall");
        tick();
        drv(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b0);
        exp_at(0, S_EX,    16'h1, "lu_ex_lw");
        exp_at(0, S_STALL, 16'h1, "lu_stall");
        exp_at(1, S_STALL, 16'h0, "lu_once");
        exp_at(1, S_EX,    16'h0, "lu_bubble");
        exp_at(1, S_MEM,   16'h2, "lu_mem_lw");
        exp_at(1, S_MD,    16'd5, "lu_md_lw");
        exp_bc(1, 16'd1, "lu_bc");
        exp_at(2, S_EX,    16'hC, "lu_ex_add");
        exp_at(2, S_MD,    16'd0, "lu_md_bub");
        exp_at(2, S_WB,    16'h3, "lu_wb_lw");
        exp_at(2, S_WD,    16'd5, "lu_wd_lw");
        exp_at(3, S_MD,    16'd7, "lu_md_add");
        tick(); tick();
        nop(4);

        // Consecutive loads each with a dependent: exactly one stall per pair
        drv(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0);
        tick();
        drv(4'b0001, 3'b010, 2'b11, 5'd5, 5'd6, 5'd0, 1'b0);
        exp_at(0, S_STALL, 16'h1, "ll_stall1");
        exp_at(1, S_STALL, 16'h0, "ll_once1");
        tick(); tick();
        drv(4'b1100, 3'b000, 2'b10, 5'd6, 5'd1, 5'd2, 1'b0);
        exp_at(0, S_STALL, 16'h1, "ll_stall2");
        exp_at(1, S_STALL, 16'h0, "ll_once2");
        exp_bc(1, 16'd3, "ll_bc");
        tick(); tick();
        nop(4);

        // BEQ with don't-care bits, taken in MEM: flush one cycle
        bex = 4'bx010; bwb = 2'b0x;
        cwb = cl4({2'b00, bwb});
        drv(bex, 3'b100, bwb, 5'd1, 5'd2, 5'd9, 1'b0);
        exp_at(1, S_EX, 16'(cl4(bex)), "beq_ex_x");
        tick();
        drv(4'b0001, 3'b001, 2'b00, 5'd0, 5'd3, 5'd0, 1'b0);
        tick();
        drv(4'b1100, 3'b000, 2'b10, 5'd0, 5'd4, 5'd5, 1'b1);
        exp_at(0, S_MEM,   16'h4, "fl_mem_beq");
        exp_at(0, S_FLUSH, 16'h1, "fl_flush");
        exp_at(0, S_STALL, 16'h0, "fl_nostall");
        exp_at(1, S_FLUSH, 16'h0, "fl_once");
        exp_at(1, S_EX,    16'h0, "fl_ex");
        exp_at(1, S_MEM,   16'h0, "fl_mem");
        exp_at(1, S_MD,    16'h0, "fl_md");
        exp_at(1, S_WB,    16'(cwb), "fl_wb_x");
        exp_at(1, S_WD,    cl4(bex) > 4'h7 ? 16'd9 : 16'd2, "fl_wd");
        exp_bc(1, 16'd4, "fl_bc");
        tick();
        nop(4);

        // Flush and load-use in the same cycle: flush wins, one count
        drv(4'b0010, 3'b100, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drv(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0);
        tick();
        drv(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b1);
        exp_at(0, S_EX,    16'h1, "both_ex_lw");
        exp_at(0, S_FLUSH, 16'h1, "both_flush");
        exp_at(0, S_STALL, 16'h0, "both_nostall");
        exp_at(1, S_EX,    16'h0, "both_ex");
        exp_at(1, S_MEM,   16'h0, "both_mem");
        exp_bc(1, 16'd5, "both_bc");
        tick();
        nop(4);

        // Reset pulse between edges during a stall
        drv(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0);
        tick();
        drv(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b0);
        exp_at(0, S_STALL, 16'h1, "rs_stall_pre");
        @(negedge clk); #1 rst_n = 1'b0;
        #1 chk_all_zero("rs_mid");
        #1 rst_n = 1'b1;
        tick();
        exp_at(0, S_EX,    16'hC, "rs_relatch");
        exp_at(0, S_STALL, 16'h0, "rs_nostall");
        exp_bc(0, 16'd0, "rs_bc");
        bsw = 4'bx001; bwb = 2'b0x;
        drv(bsw, 3'b001, bwb, 5'd0, 5'd9, 5'd8, 1'b0);
        exp_at(1, S_EX,  16'(cl4(bsw)), "sw_ex");
        exp_at(2, S_MEM, 16'h1, "sw_mem");
        exp_at(2, S_MD,  cl4(bsw) > 4'h7 ? 16'd8 : 16'd9, "sw_md");
        tick();
        nop(4);

`ifdef CTRL_PIPELINE_STATS_EN
        // Saturation: preload near the top, then two more stalls
        @(negedge clk); #1 force dut.bubble_q = 16'hFFFE;
        #1 release dut.bubble_q;
        tick();
        for (int p = 0; p < 2; p++) begin
            drv(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 5'd0, 1'b0);
            tick();
            drv(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b0);
            exp_at(0, S_STALL, 16'h1, "sat_stall");
            exp_at(1, S_BC, 16'hFFFF, p == 0 ? "sat_reach" : "sat_hold");
            tick(); tick();
        end
        nop(4);
`endif

        chk("sb_drain", 16'(sb.size()), 16'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
